// File: rtl/rps_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : rps_pkg
// Brief  : Shared result, winner and state encodings for the RPS match scorer
// Rev    : 1.0
// ---------------------------------------------------------------------------
package rps_pkg;

  typedef enum logic [1:0] {
    RES_TIE = 2'b00,
    RES_P1  = 2'b01,
    RES_P2  = 2'b10,
    RES_INV = 2'b11
  } res_code_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_e;

  typedef enum logic {
    ST_PLAY = 1'b0,
    ST_DONE = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/rps_sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : rps_sat_counter
// Brief  : Up-counter that holds at all-ones; synchronous clear, async reset
// Rev    : 1.0
// ---------------------------------------------------------------------------
module rps_sat_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] c_max = '1;

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != c_max)) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign q = cnt_q;

endmodule
`default_nettype wire

// File: rtl/rps_match_scorer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : rps_match_scorer
// Brief  : Accumulates judged RPS rounds, declares the match winner, freezes
// Rev    : 1.0
// ---------------------------------------------------------------------------
module rps_match_scorer
  import rps_pkg::*;
#(
  parameter int ROUNDS_TO_WIN = 3,
  parameter int SCORE_W       = 3,
  parameter int ROUND_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               res_valid,
  input  logic [1:0]         res_code,
  output logic               res_ready,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [SCORE_W-1:0] tie_cnt,
  output logic [SCORE_W-1:0] inv_cnt,
  output logic [ROUND_W-1:0] round_cnt,
  output logic [1:0]         last_code,
  output logic               point_pulse,
  output logic               inv_pulse,
  output logic               match_over,
  output logic [1:0]         match_winner
);

  generate
    if ((ROUNDS_TO_WIN < 1) || (ROUNDS_TO_WIN > (2**SCORE_W) - 1)) begin : g_bad_rounds_to_win
      $error("rps_match_scorer: ROUNDS_TO_WIN out of range for SCORE_W");
    end
  endgenerate

  localparam logic [SCORE_W-1:0] c_win_score = SCORE_W'(ROUNDS_TO_WIN);

  state_e             state_q;
  logic [SCORE_W-1:0] p1_q, p2_q;
  logic [SCORE_W-1:0] p1_d, p2_d;
  logic [1:0]         last_code_q;
  logic [1:0]         winner_q;
  logic               point_pulse_q;
  logic               inv_pulse_q;
  logic               w_accept;

  assign w_accept = res_valid && (state_q == ST_PLAY);
  assign p1_d     = p1_q + SCORE_W'(1);
  assign p2_d     = p2_q + SCORE_W'(1);

  // clr is wired straight in so it overrides any simultaneous accept.
  rps_sat_counter #(.WIDTH(SCORE_W)) u_tie_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (w_accept && (res_code == RES_TIE)),
    .q   (tie_cnt)
  );

  rps_sat_counter #(.WIDTH(SCORE_W)) u_inv_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (w_accept && (res_code == RES_INV)),
    .q   (inv_cnt)
  );

  rps_sat_counter #(.WIDTH(ROUND_W)) u_round_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (w_accept),
    .q   (round_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_PLAY;
      p1_q          <= '0;
      p2_q          <= '0;
      last_code_q   <= RES_TIE;
      winner_q      <= WIN_NONE;
      point_pulse_q <= 1'b0;
      inv_pulse_q   <= 1'b0;
    end else if (clr) begin
      state_q       <= ST_PLAY;
      p1_q          <= '0;
      p2_q          <= '0;
      last_code_q   <= RES_TIE;
      winner_q      <= WIN_NONE;
      point_pulse_q <= 1'b0;
      inv_pulse_q   <= 1'b0;
    end else begin
      point_pulse_q <= 1'b0;
      inv_pulse_q   <= 1'b0;
      if (w_accept) begin
        last_code_q <= res_code;
        case (res_code)
          RES_P1: begin
            p1_q          <= p1_d;
            point_pulse_q <= 1'b1;
            if (p1_d == c_win_score) begin
              state_q  <= ST_DONE;
              winner_q <= WIN_P1;
            end
          end
          RES_P2: begin
            p2_q          <= p2_d;
            point_pulse_q <= 1'b1;
            if (p2_d == c_win_score) begin
              state_q  <= ST_DONE;
              winner_q <= WIN_P2;
            end
          end
          RES_INV: inv_pulse_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign res_ready    = (state_q == ST_PLAY);
  assign match_over   = (state_q == ST_DONE);
  assign p1_score     = p1_q;
  assign p2_score     = p2_q;
  assign last_code    = last_code_q;
  assign match_winner = winner_q;
  assign point_pulse  = point_pulse_q;
  assign inv_pulse    = inv_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_rps_match_scorer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_rps_match_scorer
// Brief  : Directed and random checks of rps_match_scorer against a score model
// Rev    : 1.0
// ---------------------------------------------------------------------------
module tb_rps_match_scorer;

  localparam int ROUNDS_TO_WIN = 3;
  localparam int SCORE_W       = 3;
  localparam int ROUND_W       = 8;
  localparam int SCORE_MAX     = (1 << SCORE_W) - 1;
  localparam int ROUND_MAX     = (1 << ROUND_W) - 1;

  logic               clk = 1'b0;
  logic               rst, clr, res_valid;
  logic [1:0]         res_code;
  logic               res_ready, point_pulse, inv_pulse, match_over;
  logic [SCORE_W-1:0] p1_score, p2_score, tie_cnt, inv_cnt;
  logic [ROUND_W-1:0] round_cnt;
  logic [1:0]         last_code, match_winner;

  int checks = 0;
  int errors = 0;

  // Reference model state: plain match bookkeeping.
  int m_p1, m_p2, m_tie, m_inv, m_rounds, m_last, m_winner, m_pp, m_ip;
  bit m_over;

  rps_match_scorer #(
    .ROUNDS_TO_WIN (ROUNDS_TO_WIN),
    .SCORE_W       (SCORE_W),
    .ROUND_W       (ROUND_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .res_valid    (res_valid),
    .res_code     (res_code),
    .res_ready    (res_ready),
    .p1_score     (p1_score),
    .p2_score     (p2_score),
    .tie_cnt      (tie_cnt),
    .inv_cnt      (inv_cnt),
    .round_cnt    (round_cnt),
    .last_code    (last_code),
    .point_pulse  (point_pulse),
    .inv_pulse    (inv_pulse),
    .match_over   (match_over),
    .match_winner (match_winner)
  );

  always #5 clk = ~clk;

  function automatic int sat_inc(int v, int lim);
    return (v < lim) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    m_p1 = 0; m_p2 = 0; m_tie = 0; m_inv = 0; m_rounds = 0;
    m_last = 0; m_winner = 0; m_pp = 0; m_ip = 0; m_over = 0;
  endtask

  task automatic model_edge(input bit c, input bit v, input int code);
    if (c) begin
      model_reset();
      return;
    end
    m_pp = 0;
    m_ip = 0;
    if (v && !m_over) begin
      m_last   = code;
      m_rounds = sat_inc(m_rounds, ROUND_MAX);
      case (code)
        0: m_tie = sat_inc(m_tie, SCORE_MAX);
        3: begin m_inv = sat_inc(m_inv, SCORE_MAX); m_ip = 1; end
        1: begin
          m_p1++; m_pp = 1;
          if (m_p1 == ROUNDS_TO_WIN) begin m_over = 1; m_winner = 1; end
        end
        default: begin
          m_p2++; m_pp = 1;
          if (m_p2 == ROUNDS_TO_WIN) begin m_over = 1; m_winner = 2; end
        end
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".p1_score"},     p1_score,     m_p1);
    chk({ctx, ".p2_score"},     p2_score,     m_p2);
    chk({ctx, ".tie_cnt"},      tie_cnt,      m_tie);
    chk({ctx, ".inv_cnt"},      inv_cnt,      m_inv);
    chk({ctx, ".round_cnt"},    round_cnt,    m_rounds);
    chk({ctx, ".last_code"},    last_code,    m_last);
    chk({ctx, ".point_pulse"},  point_pulse,  m_pp);
    chk({ctx, ".inv_pulse"},    inv_pulse,    m_ip);
    chk({ctx, ".match_over"},   match_over,   32'(m_over));
    chk({ctx, ".res_ready"},    res_ready,    32'(!m_over));
    chk({ctx, ".match_winner"}, match_winner, m_winner);
  endtask

  // Apply one cycle of inputs, let the edge happen, then compare shortly after.
  task automatic step(input string ctx, input bit c, input bit v, input int code);
    clr       = c;
    res_valid = v;
    res_code  = 2'(code);
    @(posedge clk);
    model_edge(c, v, code);
    #1;
    check_all(ctx);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; res_valid = 1'b0; res_code = 2'b00;
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b0;

    // Three P1 points end the match.
    for (int i = 0; i < 3; i++) step("p1_win", 0, 1, 1);
    step("clr1", 1, 0, 0);

    // Mixed sequence, P2 wins on the last accept.
    begin
      int seq [6] = '{0, 3, 2, 1, 2, 2};
      foreach (seq[i]) step("mixed", 0, 1, seq[i]);
    end

    // Frozen in DONE.
    for (int i = 0; i < 4; i++) step("done_hold", 0, 1, 1);

    // clr wins over a simultaneous accept.
    step("clr_vs_accept", 1, 1, 1);

    // Tie counter saturation.
    for (int i = 0; i < 9; i++) step("tie_sat", 0, 1, 0);
    step("clr2", 1, 0, 0);

    // Round counter saturation without ending the match.
    for (int i = 0; i < 260; i++) step("round_sat", 0, 1, (i % 2) ? 3 : 0);
    step("clr3", 1, 0, 0);

    // Async reset between edges, mid-match at p1=2.
    step("pre_rst", 0, 1, 1);
    step("pre_rst", 0, 1, 1);
    res_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #2;
    rst = 1'b0;
    step("post_rst", 0, 1, 2);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step("random", ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7),
           int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
